// File: rtl/imem_fetch_port.sv
// Block-RAM instruction memory with a registered, single-entry valid/ready fetch port
// and a byte-masked loader write port. Define IMEM_PARITY_EN to add per-byte even parity.
module imem_fetch_port #(
    parameter int unsigned     DEPTH_BYTES = 2048,
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] NOP_WORD    = 32'h00000013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_pc,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_instr,
    output logic [XLEN-1:0] rsp_pc,
    output logic [1:0]      rsp_fault,
    input  logic            flush,
    input  logic            wr_en,
    input  logic [XLEN-1:0] wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic [3:0]      wr_strb,
    output logic [31:0]     fetch_count
);

    localparam int unsigned     WORDS = DEPTH_BYTES / 4;
    localparam int unsigned     AW    = $clog2(WORDS);
    localparam logic [XLEN-1:0] LIMIT = XLEN'(DEPTH_BYTES);

    localparam logic [1:0] FAULT_OK     = 2'b00;
    localparam logic [1:0] FAULT_ALIGN  = 2'b01;
    localparam logic [1:0] FAULT_RANGE  = 2'b10;
    localparam logic [1:0] FAULT_PARITY = 2'b11;

    logic [3:0][7:0] mem [WORDS];
    logic [31:0]     rd_data_q;

    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [1:0]      fault_q;
    logic [31:0]     count_q;

    logic            accept;
    logic [1:0]      req_fault;
    logic            rd_en;
    logic            mem_we;
    logic [AW-1:0]   rd_idx;
    logic [AW-1:0]   wr_idx;
    logic            unused_wr_low;

    assign unused_wr_low = ^wr_addr[1:0];

    // Output stage holds one entry; it frees up as soon as the consumer takes it.
    assign req_ready = !valid_q || rsp_ready;
    assign accept    = req_valid && req_ready && reset;

    always_comb begin
        req_fault = FAULT_OK;
        if (req_pc[1:0] != 2'b00) begin
            req_fault = FAULT_ALIGN;
        end else if (req_pc >= LIMIT) begin
            req_fault = FAULT_RANGE;
        end
    end

    assign rd_en  = accept && (req_fault == FAULT_OK);
    assign rd_idx = req_pc[AW+1:2];
    assign wr_idx = wr_addr[AW+1:2];
    assign mem_we = wr_en && reset && (wr_addr < LIMIT);

    // Nonblocking read and write on the same edge give read-first behaviour.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_strb[i]) begin
                    mem[wr_idx][i] <= wr_data[8*i +: 8];
                end
            end
        end
        if (!reset) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[rd_idx];
        end
    end

`ifdef IMEM_PARITY_EN
    logic [3:0] par_mem [WORDS];
    logic [3:0] rd_par_q;
    logic       parity_err;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_strb[i]) begin
                    par_mem[wr_idx][i] <= ^wr_data[8*i +: 8];
                end
            end
        end
        if (!reset) begin
            rd_par_q <= '0;
        end else if (rd_en) begin
            rd_par_q <= par_mem[rd_idx];
        end
    end

    always_comb begin
        parity_err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if ((^rd_data_q[8*i +: 8]) != rd_par_q[i]) begin
                parity_err = 1'b1;
            end
        end
    end

    // Alignment and range faults are captured at accept and take precedence.
    always_comb begin
        rsp_fault = fault_q;
        if (fault_q == FAULT_OK && parity_err) begin
            rsp_fault = FAULT_PARITY;
        end
        rsp_instr = (rsp_fault != FAULT_OK) ? NOP_WORD : rd_data_q;
    end
`else
    always_comb begin
        rsp_fault = fault_q;
        rsp_instr = (fault_q != FAULT_OK) ? NOP_WORD : rd_data_q;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            fault_q <= FAULT_OK;
            count_q <= '0;
        end else if (accept) begin
            valid_q <= 1'b1;
            pc_q    <= req_pc;
            fault_q <= req_fault;
            if (count_q != 32'hFFFF_FFFF) begin
                count_q <= count_q + 32'd1;
            end
        end else if (rsp_ready || flush) begin
            valid_q <= 1'b0;
        end
    end

    assign rsp_valid   = valid_q;
    assign rsp_pc      = pc_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_imem_fetch_port.sv
// Directed and random checks of imem_fetch_port against a transaction-level model
// (byte-array memory plus expected response/counter state).
module tb_imem_fetch_port;

    localparam int unsigned DEPTH = 2048;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        rsp_ready = 1'b0;
    logic        flush = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] req_pc = '0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_strb = '0;

    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_pc;
    logic [1:0]  rsp_fault;
    logic [31:0] fetch_count;

    always #5 clk = ~clk;

    imem_fetch_port #(
        .DEPTH_BYTES (DEPTH),
        .XLEN        (32),
        .NOP_WORD    (NOP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_pc      (req_pc),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_instr   (rsp_instr),
        .rsp_pc      (rsp_pc),
        .rsp_fault   (rsp_fault),
        .flush       (flush),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_strb     (wr_strb),
        .fetch_count (fetch_count)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0]  mmem [DEPTH];
    logic        m_known = 1'b0;
    logic        m_valid = 1'b0;
    logic        m_show = 1'b0;
    logic [31:0] m_pc = '0;
    logic [31:0] m_instr = '0;
    logic [1:0]  m_fault = '0;
    logic [31:0] m_count = '0;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs are set at the falling edge; this predicts the next rising edge and checks after it.
    task automatic cycle();
        logic ready_m;
        logic acc;
        logic [1:0] f;
        int base;
        ready_m = !m_valid || rsp_ready;
        #1;
        if (m_known) chk32("req_ready", 32'(req_ready), 32'(ready_m));
        acc = req_valid && ready_m && reset;
        if (!reset) begin
            m_valid = 1'b0; m_pc = '0; m_instr = '0; m_fault = '0; m_count = '0;
            m_known = 1'b1; m_show = 1'b1;
        end else begin
            m_show = 1'b0;
            if (acc) begin
                if (req_pc[1:0] != 2'b00) f = 2'b01;
                else if (req_pc >= DEPTH) f = 2'b10;
                else f = 2'b00;
                m_valid = 1'b1; m_pc = req_pc; m_fault = f; m_show = 1'b1;
                if (f != 2'b00) begin
                    m_instr = NOP;
                end else begin
                    base = int'(req_pc);
                    m_instr = {mmem[base+3], mmem[base+2], mmem[base+1], mmem[base]};
                end
                if (m_count != 32'hFFFF_FFFF) m_count++;
            end else if ((m_valid && rsp_ready) || flush) begin
                m_valid = 1'b0;
            end
            if (wr_en && wr_addr < DEPTH) begin
                base = int'({wr_addr[31:2], 2'b00});
                for (int i = 0; i < 4; i++)
                    if (wr_strb[i]) mmem[base+i] = wr_data[8*i +: 8];
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk32("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        chk32("fetch_count", fetch_count, m_count);
        if (m_valid || m_show) begin
            chk32("rsp_pc", rsp_pc, m_pc);
            chk32("rsp_instr", rsp_instr, m_instr);
            chk32("rsp_fault", 32'(rsp_fault), 32'(m_fault));
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
        cycle();
        wr_en = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) mmem[i] = 8'h00;

        // Reset
        reset = 1'b0;
        cycle();
        cycle();
        chk32("reset_count", fetch_count, 32'd0);
        chk32("reset_valid", 32'(rsp_valid), 32'd0);
        reset = 1'b1;

        // Load and back-to-back fetch
        wr(32'h0, 32'h02800213, 4'hF);
        wr(32'h4, 32'h00408093, 4'hF);
        wr(32'h8, 32'h0000A183, 4'hF);
        rsp_ready = 1'b1; req_valid = 1'b1;
        req_pc = 32'h0; cycle();
        chk32("b2b_w0", rsp_instr, 32'h02800213);
        req_pc = 32'h4; cycle();
        chk32("b2b_w1", rsp_instr, 32'h00408093);
        req_pc = 32'h8; cycle();
        chk32("b2b_w2", rsp_instr, 32'h0000A183);
        chk32("b2b_count", fetch_count, 32'd3);
        req_valid = 1'b0; cycle();

        // Stall
        rsp_ready = 1'b0; req_valid = 1'b1; req_pc = 32'h0; cycle();
        req_pc = 32'h4;
        repeat (3) begin
            cycle();
            chk32("stall_hold", rsp_instr, 32'h02800213);
        end
        chk32("stall_ready", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1; cycle();
        chk32("stall_release", rsp_instr, 32'h00408093);
        req_valid = 1'b0; cycle();

        // Faults
        req_valid = 1'b1;
        req_pc = 32'h2;   cycle();
        chk32("fault_mis", 32'(rsp_fault), 32'd1);
        chk32("fault_mis_nop", rsp_instr, NOP);
        req_pc = 32'h800; cycle();
        chk32("fault_range", 32'(rsp_fault), 32'd2);
        req_pc = 32'h802; cycle();
        chk32("fault_both", 32'(rsp_fault), 32'd1);
        req_valid = 1'b0; cycle();

        // Flush
        rsp_ready = 1'b0; req_valid = 1'b1; req_pc = 32'h0; cycle();
        req_valid = 1'b0; flush = 1'b1; cycle();
        chk32("flush_drop", 32'(rsp_valid), 32'd0);
        flush = 1'b0; rsp_ready = 1'b1; req_valid = 1'b1; req_pc = 32'h0; cycle();
        flush = 1'b1; req_pc = 32'h4; cycle();
        chk32("flush_acc_pc", rsp_pc, 32'h4);
        flush = 1'b0; req_valid = 1'b0; cycle();

        // Byte write with read-first fetch
        req_valid = 1'b1; req_pc = 32'h0;
        wr(32'h0, 32'h0000AB00, 4'b0010);
        chk32("rf_old", rsp_instr, 32'h02800213);
        cycle();
        chk32("rf_new", rsp_instr, 32'h0280AB13);
        req_valid = 1'b0; cycle();

        // Reset while stalled
        rsp_ready = 1'b0; req_valid = 1'b1; req_pc = 32'h0; cycle();
        reset = 1'b0; cycle();
        chk32("rst_mid_valid", 32'(rsp_valid), 32'd0);
        chk32("rst_mid_count", fetch_count, 32'd0);
        reset = 1'b1; rsp_ready = 1'b1; cycle();
        chk32("rst_mid_mem", rsp_instr, 32'h0280AB13);
        req_valid = 1'b0; cycle();

        // Random traffic over a fully written 256-byte region
        for (int w = 0; w < 64; w++) wr(32'(w * 4), $urandom, 4'hF);
        for (int n = 0; n < 400; n++) begin
            int sel;
            req_valid = ($urandom_range(0, 3) != 0);
            rsp_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 7) == 0);
            sel = $urandom_range(0, 9);
            if (sel < 7)      req_pc = 32'($urandom_range(0, 63) * 4);
            else if (sel < 9) req_pc = 32'($urandom_range(0, 255));
            else              req_pc = $urandom | 32'h800;
            wr_en   = ($urandom_range(0, 5) == 0);
            wr_addr = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h800)
                                                  : 32'($urandom_range(0, 255));
            wr_data = $urandom;
            wr_strb = 4'($urandom_range(0, 15));
            cycle();
        end
        req_valid = 1'b0; wr_en = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
